serial_pattern_tx: RTL and testbench

Serial bit-pattern transmitter, the driving end of the serial sequence-detector interface. It accepts a WIDTH-bit pattern, either a built-in default or one supplied on the port, plus a repeat count. It shifts the pattern out MSB-first, one bit per clock, on a single-bit stream that connects directly to a detector's din. Typical use is as an on-chip stimulus source for the Moore/Mealy detectors, including back-to-back repeats that exercise overlapping detection.

---
 rtl/serial_pattern_tx.sv | 161 ++++++++++++++++
 tb/tb_serial_pattern_tx.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_pattern_tx.sv
// serial_pattern_tx
//   Serial bit-pattern transmitter. Accepts a WIDTH-bit pattern (built-in
//   DEFAULT_PATTERN or pattern_in) plus a repeat count, then shifts the
//   pattern out MSB-first, one bit per clock, optionally separating repeats
//   with GAP idle cycles. Intended to drive the din of a sequence detector.
//
// Ports
//   clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   start        burst request, sampled only while idle
//   use_default  1 = send DEFAULT_PATTERN, 0 = send pattern_in
//   pattern_in   user pattern, latched when start is accepted
//   repeat_cnt   number of pattern transmissions (0 behaves as 1)
//   abort        terminate the current burst without a done pulse
//   dout         serial data, MSB first (IDLE_LEVEL when not sending)
//   dout_valid   high while dout carries a pattern bit
//   busy         high from the accepted start until the burst ends
//   done         one-cycle pulse after the last bit of a completed burst
module serial_pattern_tx #(
   parameter int               WIDTH           = 5,
   parameter logic [WIDTH-1:0] DEFAULT_PATTERN = WIDTH'(5'b10011),
   parameter int               CNT_W           = 4,
   parameter int               GAP             = 0,
   parameter logic             IDLE_LEVEL      = 1'b0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             start,
   input  logic             use_default,
   input  logic [WIDTH-1:0] pattern_in,
   input  logic [CNT_W-1:0] repeat_cnt,
   input  logic             abort,
   output logic             dout,
   output logic             dout_valid,
   output logic             busy,
   output logic             done
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_GAP} state_t;

   localparam int BIT_W = $clog2(WIDTH);
   localparam int GAP_W = (GAP > 1) ? $clog2(GAP) : 1;
   localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(WIDTH - 1);
   localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP > 0) ? GAP - 1 : 0);

   state_t             state_q;
   logic [WIDTH-1:0]   pat_q;       // pattern held for reloading on each repeat
   logic [WIDTH-1:0]   shreg_q;     // bits still to be sent in this repeat, MSB next
   logic [BIT_W-1:0]   bit_cnt_q;   // index of the bit currently on dout
   logic [CNT_W-1:0]   rep_q;       // repeats remaining, including the current one
   logic [GAP_W-1:0]   gap_cnt_q;
   logic               dout_q;
   logic               valid_q;
   logic               busy_q;
   logic               done_q;

   logic [WIDTH-1:0]   pat_d;
   logic [CNT_W-1:0]   reps_d;

   always_comb begin
      pat_d  = use_default ? DEFAULT_PATTERN : pattern_in;
      reps_d = (repeat_cnt == '0) ? CNT_W'(1) : repeat_cnt;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= S_IDLE;
         pat_q     <= '0;
         shreg_q   <= '0;
         bit_cnt_q <= '0;
         rep_q     <= '0;
         gap_cnt_q <= '0;
         dout_q    <= IDLE_LEVEL;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               // abort is deliberately not looked at here, so abort+start still starts
               if (start) begin
                  pat_q     <= pat_d;
                  shreg_q   <= {pat_d[WIDTH-2:0], 1'b0};
                  dout_q    <= pat_d[WIDTH-1];
                  valid_q   <= 1'b1;
                  busy_q    <= 1'b1;
                  bit_cnt_q <= '0;
                  rep_q     <= reps_d;
                  state_q   <= S_SHIFT;
               end
            end

            S_SHIFT: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  dout_q  <= IDLE_LEVEL;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (bit_cnt_q == BIT_LAST) begin
                  if (rep_q > CNT_W'(1)) begin
                     rep_q <= rep_q - CNT_W'(1);
                     if (GAP == 0) begin
                        // seamless concatenation: next repeat's MSB on the very next edge
                        dout_q    <= pat_q[WIDTH-1];
                        shreg_q   <= {pat_q[WIDTH-2:0], 1'b0};
                        bit_cnt_q <= '0;
                     end else begin
                        state_q   <= S_GAP;
                        gap_cnt_q <= '0;
                        dout_q    <= IDLE_LEVEL;
                        valid_q   <= 1'b0;
                     end
                  end else begin
                     state_q <= S_IDLE;
                     rep_q   <= '0;
                     dout_q  <= IDLE_LEVEL;
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end
               end else begin
                  dout_q    <= shreg_q[WIDTH-1];
                  shreg_q   <= {shreg_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q <= bit_cnt_q + 1'b1;
               end
            end

            S_GAP: begin
               if (abort) begin
                  state_q <= S_IDLE;
                  dout_q  <= IDLE_LEVEL;
                  valid_q <= 1'b0;
                  busy_q  <= 1'b0;
               end else if (gap_cnt_q == GAP_LAST) begin
                  state_q   <= S_SHIFT;
                  dout_q    <= pat_q[WIDTH-1];
                  shreg_q   <= {pat_q[WIDTH-2:0], 1'b0};
                  bit_cnt_q <= '0;
                  valid_q   <= 1'b1;
               end else begin
                  gap_cnt_q <= gap_cnt_q + 1'b1;
               end
            end

            default: begin
               state_q <= S_IDLE;
               dout_q  <= IDLE_LEVEL;
               valid_q <= 1'b0;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dout       = dout_q;
   assign dout_valid = valid_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
module tb_serial_pattern_tx;

   typedef logic [3:0] vq_t[$];

   localparam logic [4:0] DEF_PAT = 5'b10011;
   localparam logic [3:0] IDLE_V  = 4'b0000;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic       use_default = 1'b0;
   logic [4:0] pattern_in = '0;
   logic [3:0] repeat_cnt = '0;
   logic       abort = 1'b0;

   logic dout0, valid0, busy0, done0;
   logic dout2, valid2, busy2, done2;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   serial_pattern_tx #(.WIDTH(5), .DEFAULT_PATTERN(5'b10011), .CNT_W(4), .GAP(0), .IDLE_LEVEL(1'b0)) dut0 (
      .clk(clk), .reset(reset), .start(start), .use_default(use_default),
      .pattern_in(pattern_in), .repeat_cnt(repeat_cnt), .abort(abort),
      .dout(dout0), .dout_valid(valid0), .busy(busy0), .done(done0));

   serial_pattern_tx #(.WIDTH(5), .DEFAULT_PATTERN(5'b10011), .CNT_W(4), .GAP(2), .IDLE_LEVEL(1'b0)) dut2 (
      .clk(clk), .reset(reset), .start(start), .use_default(use_default),
      .pattern_in(pattern_in), .repeat_cnt(repeat_cnt), .abort(abort),
      .dout(dout2), .dout_valid(valid2), .busy(busy2), .done(done2));

   // Reference: the cycle-by-cycle output stream {dout,dout_valid,busy,done}
   // starting with cycle 1 after the start edge, ending with the done cycle.
   function automatic vq_t model(input logic [4:0] p, input int rcnt, input int gap);
      vq_t q;
      int reps;
      reps = (rcnt == 0) ? 1 : rcnt;
      for (int r = 0; r < reps; r++) begin
         for (int b = 4; b >= 0; b--) q.push_back({p[b], 3'b110});
         if (r < reps - 1)
            for (int g = 0; g < gap; g++) q.push_back(4'b0010);
      end
      q.push_back(4'b0001);
      return q;
   endfunction

   // Starts a burst (inputs applied at a negedge, accepted at the next posedge)
   // and checks both instances each cycle. Optional: abort raised together
   // with start, a stray start pulse in cycle 3, and stopping in the done cycle
   // so the caller can chain a new start right there.
   task automatic run_burst(input string name, input logic [4:0] pat, input bit ud,
                            input int rcnt, input bit abort_with_start,
                            input bit stray_start, input bit stop_at_done);
      vq_t e0, e2;
      logic [4:0] eff;
      int last;
      eff = ud ? DEF_PAT : pat;
      e0 = model(eff, rcnt, 0);
      e2 = model(eff, rcnt, 2);
      pattern_in  = pat;
      use_default = ud;
      repeat_cnt  = 4'(rcnt);
      start       = 1'b1;
      abort       = abort_with_start;
      @(posedge clk);
      #1;
      start = 1'b0;
      abort = 1'b0;
      last = (e2.size() > e0.size()) ? e2.size() : e0.size();
      if (!stop_at_done) last = last + 1;
      for (int c = 1; c <= last; c++) begin
         logic [3:0] x0, x2, o0, o2;
         @(negedge clk);
         x0 = (c <= e0.size()) ? e0[c-1] : IDLE_V;
         x2 = (c <= e2.size()) ? e2[c-1] : IDLE_V;
         o0 = {dout0, valid0, busy0, done0};
         o2 = {dout2, valid2, busy2, done2};
         checks++;
         if (o0 !== x0) begin
            failures++;
            $display("FAIL %s gap0 cycle %0d got=%b want=%b", name, c, o0, x0);
         end
         checks++;
         if (o2 !== x2) begin
            failures++;
            $display("FAIL %s gap2 cycle %0d got=%b want=%b", name, c, o2, x2);
         end
         // inputs wander during the burst; they must not matter
         if (!(stop_at_done && c == last)) begin
            pattern_in  = 5'($urandom);
            use_default = 1'($urandom);
            start       = (stray_start && c == 3);
         end
      end
   endtask

   task automatic check_idle(input string name, input int n);
      for (int c = 0; c < n; c++) begin
         @(negedge clk);
         checks++;
         if ({dout0, valid0, busy0, done0} !== IDLE_V) begin
            failures++;
            $display("FAIL %s gap0 idle %0d got=%b want=%b", name, c, {dout0, valid0, busy0, done0}, IDLE_V);
         end
         checks++;
         if ({dout2, valid2, busy2, done2} !== IDLE_V) begin
            failures++;
            $display("FAIL %s gap2 idle %0d got=%b want=%b", name, c, {dout2, valid2, busy2, done2}, IDLE_V);
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(posedge clk);
      check_idle("reset", 1);
      reset = 1'b0;
      check_idle("post_reset", 2);
   endtask

   task automatic test_default_single;
      run_burst("default_r1", 5'b00000, 1'b1, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_default_repeat2;
      run_burst("default_r2", 5'b00000, 1'b1, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_user_gap;
      run_burst("user_11010_r2", 5'b11010, 1'b0, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_zero_repeat_and_stray_start;
      run_burst("rcnt0_stray", 5'b01101, 1'b0, 0, 1'b0, 1'b1, 1'b0);
      check_idle("rcnt0_after", 3);
   endtask

   task automatic test_max_repeat;
      run_burst("rcnt15", 5'b10110, 1'b0, 15, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_abort;
      vq_t e0, e2;
      e0 = model(DEF_PAT, 3, 0);
      e2 = model(DEF_PAT, 3, 2);
      // abort while idle does nothing
      abort = 1'b1;
      check_idle("abort_idle", 2);
      abort = 1'b0;
      // abort in cycle 3 of a burst
      use_default = 1'b1;
      repeat_cnt  = 4'd3;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      for (int c = 1; c <= 3; c++) begin
         @(negedge clk);
         checks++;
         if ({dout0, valid0, busy0, done0} !== e0[c-1]) begin
            failures++;
            $display("FAIL abort_pre gap0 cycle %0d got=%b want=%b", c, {dout0, valid0, busy0, done0}, e0[c-1]);
         end
         checks++;
         if ({dout2, valid2, busy2, done2} !== e2[c-1]) begin
            failures++;
            $display("FAIL abort_pre gap2 cycle %0d got=%b want=%b", c, {dout2, valid2, busy2, done2}, e2[c-1]);
         end
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check_idle("abort_after", 10);
      run_burst("after_abort", 5'b00000, 1'b1, 1, 1'b0, 1'b0, 1'b0);
      // abort while the GAP=2 instance sits in its gap (cycle 6)
      use_default = 1'b1;
      repeat_cnt  = 4'd2;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (6) @(negedge clk);
      checks++;
      if ({dout2, valid2, busy2, done2} !== 4'b0010) begin
         failures++;
         $display("FAIL abort_gap_pre gap2 got=%b want=%b", {dout2, valid2, busy2, done2}, 4'b0010);
      end
      abort = 1'b1;
      @(posedge clk);
      #1 abort = 1'b0;
      check_idle("abort_gap_after", 10);
      // abort together with start in idle: start wins
      run_burst("abort_with_start", 5'b11100, 1'b0, 2, 1'b1, 1'b0, 1'b0);
   endtask

   task automatic test_reset_midburst;
      use_default = 1'b1;
      repeat_cnt  = 4'd2;
      start       = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b1;
      check_idle("reset_mid", 1);
      reset = 1'b0;
      check_idle("reset_mid_after", 3);
      run_burst("after_reset", 5'b01011, 1'b0, 2, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_back_to_back;
      // single repeat: both instances finish together, start raised in done cycle
      run_burst("b2b_first", 5'b00000, 1'b1, 1, 1'b0, 1'b0, 1'b1);
      run_burst("b2b_second", 5'b10101, 1'b0, 2, 1'b0, 1'b0, 1'b1);
      run_burst("b2b_third", 5'b00000, 1'b1, 1, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic test_random_bursts;
      for (int i = 0; i < 20; i++) begin
         run_burst("random", 5'($urandom), 1'($urandom), int'($urandom_range(0, 15)),
                   1'($urandom), 1'($urandom), 1'b0);
      end
   endtask

   initial begin
      test_reset();
      test_default_single();
      test_default_repeat2();
      test_user_gap();
      test_zero_repeat_and_stray_start();
      test_max_repeat();
      test_abort();
      test_reset_midburst();
      test_back_to_back();
      test_random_bursts();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
